// File: rtl/i2c_pkg.sv
// i2c_pkg -- shared definitions for the I2C target.
//   i2c_state_t    : protocol state encoding
//   I2C_ACK/NACK   : level of the acknowledge bit on SDA
//   RW_BIT/RW_READ : position and read value of the R/W bit in the address byte
//   BITS_PER_BYTE  : bit counter value once a full byte has been shifted
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_state_t;

    localparam logic       I2C_ACK       = 1'b0;
    localparam logic       I2C_NACK      = 1'b1;
    localparam int         RW_BIT        = 0;
    localparam logic       RW_READ       = 1'b1;
    localparam logic [3:0] BITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter -- 2-FF synchronizer followed by a stability filter.
// The filtered output only follows the synchronized level after it has
// differed from the current output for FILTER_LEN consecutive cycles, so
// pad-to-filtered latency is 2 + FILTER_LEN cycles.
// Ports:
//   clk       in  clock
//   rst_n     in  asynchronous active-low reset (line idles high)
//   line_raw  in  raw pad level
//   line_filt out filtered level
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_raw,
    output logic line_filt
);

    localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

    logic       sync1_reg;
    logic       sync2_reg;
    logic       filt_reg;
    logic [3:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            filt_reg  <= 1'b1;
            cnt_reg   <= 4'd0;
        end else begin
            sync1_reg <= line_raw;
            sync2_reg <= sync1_reg;
            if (sync2_reg != filt_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    filt_reg <= sync2_reg;
                    cnt_reg  <= 4'd0;
                end else begin
                    cnt_reg <= cnt_reg + 4'd1;
                end
            end else begin
                // any glitch back to the current level restarts the count
                cnt_reg <= 4'd0;
            end
        end
    end

    assign line_filt = filt_reg;

endmodule

// File: rtl/axis_i2c_starget.sv
// axis_i2c_starget -- I2C target with AXI-stream write/read data ports.
// Decodes START/STOP and a 7-bit address; master-written bytes leave on
// m_wr_*, bytes read by the master are taken from s_rd_*.
// Optional feature macro: I2C_STARGET_STRETCH_EN enables SCL clock stretching
// (full write holding register, or no read data available). Without it scl_t
// is tied to 1, a write into a full register is NACKed and dropped, and a
// read with no data returns 0xFF.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   sda_i, scl_i            raw pad inputs
//   sda_t, scl_t            tristate controls (1 = release, 0 = pull low)
//   m_wr_data/first/valid   written byte, first-after-address flag, valid
//   m_wr_ready              write stream ready
//   s_rd_data/valid         read byte source
//   s_rd_ready              one-cycle fetch strobe for the read byte
//   evt_start, evt_stop     one-cycle event pulses
//   busy                    addressed, until STOP or next START
module axis_i2c_starget
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR       = 7'h50,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sda_i,
    input  logic       scl_i,
    output logic       sda_t,
    output logic       scl_t,
    output logic [7:0] m_wr_data,
    output logic       m_wr_first,
    output logic       m_wr_valid,
    input  logic       m_wr_ready,
    input  logic [7:0] s_rd_data,
    input  logic       s_rd_valid,
    output logic       s_rd_ready,
    output logic       evt_start,
    output logic       evt_stop,
    output logic       busy
);

    // ---------------- input conditioning ----------------
    logic [1:0] line_raw;
    logic [1:0] line_filt;
    logic       sda_f;
    logic       scl_f;

    assign line_raw = {scl_i, sda_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_filt
            i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
                .clk      (clk),
                .rst_n    (rst_n),
                .line_raw (line_raw[gi]),
                .line_filt(line_filt[gi])
            );
        end
    endgenerate

    assign sda_f = line_filt[0];
    assign scl_f = line_filt[1];

    // ---------------- state ----------------
    i2c_state_t state_reg, state_next;
    logic [3:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic [6:0] tx_reg, tx_next;          // remaining read bits, MSB next
    logic       rw_reg, rw_next;
    logic       ack_reg, ack_next;        // master's bit in RD_ACK
    logic       sda_t_reg, sda_t_next;
    logic       busy_reg, busy_next;
    logic       first_pend_reg, first_pend_next;
    logic       byte_pend_reg, byte_pend_next;  // received byte not yet stored
    logic [7:0] wr_data_reg, wr_data_next;
    logic       wr_first_reg, wr_first_next;
    logic       wr_valid_reg, wr_valid_next;
    logic       evt_start_reg, evt_stop_reg;
    logic       scl_prev_reg, sda_prev_reg;
`ifdef I2C_STARGET_STRETCH_EN
    logic       scl_t_reg, scl_t_next;
    logic       rd_wait_reg, rd_wait_next;
`endif

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;
    logic       can_load, pend_now, load_byte, fetch, rd_take;
    logic [7:0] load_data;

    assign scl_rise  = scl_f & ~scl_prev_reg;
    assign scl_fall  = ~scl_f & scl_prev_reg;
    assign start_det = scl_f & scl_prev_reg & sda_prev_reg & ~sda_f;
    assign stop_det  = scl_f & scl_prev_reg & ~sda_prev_reg & sda_f;
    assign rx_byte   = {shift_reg[6:0], sda_f};
    // holding register is free now, or is being drained this very cycle
    assign can_load  = ~wr_valid_reg | m_wr_ready;
    assign pend_now  = byte_pend_reg & ~can_load;

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        tx_next         = tx_reg;
        rw_next         = rw_reg;
        ack_next        = ack_reg;
        sda_t_next      = sda_t_reg;
        busy_next       = busy_reg;
        first_pend_next = first_pend_reg;
        byte_pend_next  = byte_pend_reg;
        wr_data_next    = wr_data_reg;
        wr_first_next   = wr_first_reg;
        wr_valid_next   = wr_valid_reg & ~m_wr_ready;
`ifdef I2C_STARGET_STRETCH_EN
        scl_t_next      = scl_t_reg;
        rd_wait_next    = rd_wait_reg;
`endif
        load_byte       = 1'b0;
        load_data       = shift_reg;
        fetch           = 1'b0;
        rd_take         = 1'b0;

        if (start_det || stop_det) begin
            state_next     = start_det ? ST_ADDR : ST_IDLE;
            bit_cnt_next   = 4'd0;
            sda_t_next     = 1'b1;
            busy_next      = 1'b0;
            byte_pend_next = 1'b0;
`ifdef I2C_STARGET_STRETCH_EN
            scl_t_next     = 1'b1;
            rd_wait_next   = 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_ADDR: begin
                    if (scl_rise && bit_cnt_reg != BITS_PER_BYTE) begin
                        shift_next   = rx_byte;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                    if (scl_fall && bit_cnt_reg == BITS_PER_BYTE) begin
                        if (shift_reg[7:1] == ADDR) begin
                            state_next      = ST_ADDR_ACK;
                            sda_t_next      = I2C_ACK;
                            busy_next       = 1'b1;
                            rw_next         = shift_reg[RW_BIT];
                            first_pend_next = 1'b1;
                        end else begin
                            state_next = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_next = 4'd0;
                        if (rw_reg == RW_READ) begin
                            state_next = ST_RD_BYTE;
                            fetch      = 1'b1;
                        end else begin
                            state_next = ST_WR_BYTE;
                            sda_t_next = 1'b1;
                        end
                    end
                end
                ST_WR_BYTE: begin
                    if (scl_rise && bit_cnt_reg != BITS_PER_BYTE) begin
                        shift_next   = rx_byte;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == BITS_PER_BYTE - 4'd1) begin
                            if (can_load) begin
                                load_byte = 1'b1;
                                load_data = rx_byte;
                            end else begin
                                byte_pend_next = 1'b1;
                            end
                        end
                    end else if (byte_pend_reg && can_load) begin
                        // register drained before the ACK slot: store now
                        load_byte      = 1'b1;
                        byte_pend_next = 1'b0;
                    end
                    if (scl_fall && bit_cnt_reg == BITS_PER_BYTE) begin
                        if (!pend_now) begin
                            state_next = ST_WR_ACK;
                            sda_t_next = I2C_ACK;
                        end else begin
`ifdef I2C_STARGET_STRETCH_EN
                            state_next = ST_WR_ACK;
                            scl_t_next = 1'b0;
`else
                            state_next     = ST_IGNORE;
                            byte_pend_next = 1'b0;
                            sda_t_next     = I2C_NACK;
`endif
                        end
                    end
                end
                ST_WR_ACK: begin
`ifdef I2C_STARGET_STRETCH_EN
                    if (byte_pend_reg) begin
                        // SCL held low; ACK and release once the byte fits
                        if (can_load) begin
                            load_byte      = 1'b1;
                            byte_pend_next = 1'b0;
                            sda_t_next     = I2C_ACK;
                            scl_t_next     = 1'b1;
                        end
                    end else if (scl_fall) begin
                        state_next   = ST_WR_BYTE;
                        sda_t_next   = 1'b1;
                        bit_cnt_next = 4'd0;
                    end
`else
                    if (scl_fall) begin
                        state_next   = ST_WR_BYTE;
                        sda_t_next   = 1'b1;
                        bit_cnt_next = 4'd0;
                    end
`endif
                end
                ST_RD_BYTE: begin
`ifdef I2C_STARGET_STRETCH_EN
                    if (rd_wait_reg) begin
                        if (s_rd_valid) begin
                            rd_take      = 1'b1;
                            tx_next      = s_rd_data[6:0];
                            sda_t_next   = s_rd_data[7];
                            scl_t_next   = 1'b1;
                            rd_wait_next = 1'b0;
                        end
                    end else
`endif
                    if (scl_fall) begin
                        if (bit_cnt_reg == BITS_PER_BYTE - 4'd1) begin
                            state_next = ST_RD_ACK;
                            sda_t_next = 1'b1;
                        end else begin
                            sda_t_next   = tx_reg[6];
                            tx_next      = {tx_reg[5:0], 1'b1};
                            bit_cnt_next = bit_cnt_reg + 4'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        ack_next = sda_f;
                    end
                    if (scl_fall) begin
                        if (ack_reg == I2C_ACK) begin
                            state_next   = ST_RD_BYTE;
                            bit_cnt_next = 4'd0;
                            fetch        = 1'b1;
                        end else begin
                            state_next = ST_IGNORE;
                        end
                    end
                end
                default: begin
                    // IDLE and IGNORE only leave on START/STOP
                end
            endcase
        end

        // start of a read byte: latch source data and drive its MSB
        if (fetch) begin
            if (s_rd_valid) begin
                rd_take    = 1'b1;
                tx_next    = s_rd_data[6:0];
                sda_t_next = s_rd_data[7];
            end else begin
`ifdef I2C_STARGET_STRETCH_EN
                scl_t_next   = 1'b0;
                rd_wait_next = 1'b1;
                sda_t_next   = 1'b1;
`else
                tx_next    = 7'h7F;
                sda_t_next = 1'b1;
`endif
            end
        end

        if (load_byte) begin
            wr_valid_next   = 1'b1;
            wr_data_next    = load_data;
            wr_first_next   = first_pend_reg;
            first_pend_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            bit_cnt_reg    <= 4'd0;
            shift_reg      <= 8'h00;
            tx_reg         <= 7'h7F;
            rw_reg         <= 1'b0;
            ack_reg        <= I2C_NACK;
            sda_t_reg      <= 1'b1;
            busy_reg       <= 1'b0;
            first_pend_reg <= 1'b0;
            byte_pend_reg  <= 1'b0;
            wr_data_reg    <= 8'h00;
            wr_first_reg   <= 1'b0;
            wr_valid_reg   <= 1'b0;
            evt_start_reg  <= 1'b0;
            evt_stop_reg   <= 1'b0;
            scl_prev_reg   <= 1'b1;
            sda_prev_reg   <= 1'b1;
`ifdef I2C_STARGET_STRETCH_EN
            scl_t_reg      <= 1'b1;
            rd_wait_reg    <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            tx_reg         <= tx_next;
            rw_reg         <= rw_next;
            ack_reg        <= ack_next;
            sda_t_reg      <= sda_t_next;
            busy_reg       <= busy_next;
            first_pend_reg <= first_pend_next;
            byte_pend_reg  <= byte_pend_next;
            wr_data_reg    <= wr_data_next;
            wr_first_reg   <= wr_first_next;
            wr_valid_reg   <= wr_valid_next;
            evt_start_reg  <= start_det;
            evt_stop_reg   <= stop_det;
            scl_prev_reg   <= scl_f;
            sda_prev_reg   <= sda_f;
`ifdef I2C_STARGET_STRETCH_EN
            scl_t_reg      <= scl_t_next;
            rd_wait_reg    <= rd_wait_next;
`endif
        end
    end

    assign sda_t      = sda_t_reg;
`ifdef I2C_STARGET_STRETCH_EN
    assign scl_t      = scl_t_reg;
`else
    assign scl_t      = 1'b1;
`endif
    assign m_wr_data  = wr_data_reg;
    assign m_wr_first = wr_first_reg;
    assign m_wr_valid = wr_valid_reg;
    assign s_rd_ready = rd_take;
    assign evt_start  = evt_start_reg;
    assign evt_stop   = evt_stop_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_axis_i2c_starget.sv
// tb_axis_i2c_starget -- bench for axis_i2c_starget. A bit-level I2C master
// model drives the open-drain bus; expected written bytes go into a queue that
// a separate monitor checks against the m_wr stream handshakes.
// Honours I2C_STARGET_STRETCH_EN for the full-holding-register case.
`timescale 1ns/1ps
module tb_axis_i2c_starget;

    localparam int H     = 40;     // clk cycles per SCL half-period
    localparam int LIMIT = 20000;  // bound on any wait for a released SCL

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sda_m = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_i, scl_i, sda_t, scl_t;
    logic [7:0] m_wr_data;
    logic       m_wr_first, m_wr_valid;
    logic       m_wr_ready = 1'b1;
    logic [7:0] s_rd_data;
    logic       s_rd_valid, s_rd_ready;
    logic       evt_start, evt_stop, busy;

    int total = 0;
    int bad = 0;
    int n_start = 0, n_stop = 0, n_rd = 0;
    int busy_seen = 0;
    int last_stretch = 0;
    int src_idx = 0;
    int src_len = 0;
    logic [7:0] src_mem [0:7];
    logic [8:0] exp_q [$];

    always #5 clk = ~clk;

    assign sda_i = sda_m & sda_t;
    assign scl_i = scl_m & scl_t;
    assign s_rd_data  = src_mem[src_idx[2:0]];
    assign s_rd_valid = (src_idx < src_len);

    axis_i2c_starget #(.ADDR(7'h50), .FILTER_LEN(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sda_i     (sda_i),
        .scl_i     (scl_i),
        .sda_t     (sda_t),
        .scl_t     (scl_t),
        .m_wr_data (m_wr_data),
        .m_wr_first(m_wr_first),
        .m_wr_valid(m_wr_valid),
        .m_wr_ready(m_wr_ready),
        .s_rd_data (s_rd_data),
        .s_rd_valid(s_rd_valid),
        .s_rd_ready(s_rd_ready),
        .evt_start (evt_start),
        .evt_stop  (evt_stop),
        .busy      (busy)
    );

    // write-stream monitor / scoreboard
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && m_wr_valid && m_wr_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL wr_unexpected got=%02h first=%0b required=none", m_wr_data, m_wr_first);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_wr_first, m_wr_data} !== e) begin
                        bad++;
                        $display("FAIL wr_byte got=%02h first=%0b required=%02h first=%0b",
                                 m_wr_data, m_wr_first, e[7:0], e[8]);
                    end else begin
                        $display("wr byte %02h first=%0b ok", m_wr_data, m_wr_first);
                    end
                end
            end
        end
    end

    // event counters and read-source consumer
    initial begin
        forever begin
            @(negedge clk);
            if (evt_start) n_start++;
            if (evt_stop)  n_stop++;
            if (busy)      busy_seen = 1;
            if (s_rd_ready) begin
                n_rd++;
                if (s_rd_valid) begin
                    @(posedge clk);
                    #1 src_idx++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check(input string name, input int got, input int req);
        total++;
        if (got != req) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end else begin
            $display("%s = %0h ok", name, got);
        end
    endtask

    task automatic scl_release(output int held);
        held = 0;
        scl_m = 1'b1;
        tick(1);
        while (scl_i == 1'b0 && held < LIMIT) begin
            tick(1);
            held++;
        end
        if (held >= LIMIT) begin
            total++;
            bad++;
            $display("FAIL scl_timeout held=%0d limit=%0d", held, LIMIT);
        end
    endtask

    task automatic put_bit(input logic b);
        int h;
        sda_m = b;
        tick(H);
        scl_release(h);
        last_stretch = h;
        tick(H);
        scl_m = 1'b0;
        tick(4);
    endtask

    task automatic get_bit(output logic b);
        int h;
        sda_m = 1'b1;
        tick(H);
        scl_release(h);
        last_stretch = h;
        tick(H / 2);
        b = sda_i;
        tick(H / 2);
        scl_m = 1'b0;
        tick(4);
    endtask

    task automatic send_start();
        int h;
        sda_m = 1'b1;
        tick(H);
        scl_release(h);
        tick(H);
        sda_m = 1'b0;
        tick(H);
        scl_m = 1'b0;
        tick(H);
    endtask

    task automatic send_stop();
        int h;
        sda_m = 1'b0;
        tick(H);
        scl_release(h);
        tick(H);
        sda_m = 1'b1;
        tick(H);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic req_ack, input string name);
        logic a;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(a);
        check(name, a, req_ack);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(ack);
    endtask

    initial begin
        int s0, p0, r0;
        logic [7:0] d;
        logic b;

        for (int i = 0; i < 8; i++) src_mem[i] = 8'h00;
        src_mem[0] = 8'h5A;
        src_mem[1] = 8'hC3;
        src_mem[2] = 8'h77;
        src_mem[3] = 8'h00;
        src_len = 4;

        // reset values
        tick(5);
        check("rst_sda_t", sda_t, 1);
        check("rst_scl_t", scl_t, 1);
        check("rst_wr_valid", m_wr_valid, 0);
        check("rst_wr_data", m_wr_data, 0);
        check("rst_wr_first", m_wr_first, 0);
        check("rst_evt", {evt_start, evt_stop}, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick(20);

        // 1: write 0xA0, 0x12, 0x34, STOP
        s0 = n_start; p0 = n_stop;
        exp_q.push_back({1'b1, 8'h12});
        exp_q.push_back({1'b0, 8'h34});
        send_start();
        write_byte(8'hA0, 1'b0, "t1_addr_ack");
        check("t1_busy", busy, 1);
        write_byte(8'h12, 1'b0, "t1_d0_ack");
        write_byte(8'h34, 1'b0, "t1_d1_ack");
        send_stop();
        tick(20);
        check("t1_starts", n_start - s0, 1);
        check("t1_stops", n_stop - p0, 1);
        check("t1_busy_end", busy, 0);

        // 2: read 0xA1 -> 0x5A (ACK), 0xC3 (NACK), then ignored
        r0 = n_rd;
        send_start();
        write_byte(8'hA1, 1'b0, "t2_addr_ack");
        read_byte(1'b0, d);
        check("t2_rd0", d, 8'h5A);
        read_byte(1'b1, d);
        check("t2_rd1", d, 8'hC3);
        read_byte(1'b1, d);
        check("t2_ignore_rd", d, 8'hFF);
        check("t2_rd_pulses", n_rd - r0, 2);
        send_stop();
        tick(20);

        // 3: foreign address 0xA2
        busy_seen = 0;
        send_start();
        write_byte(8'hA2, 1'b1, "t3_addr_nack");
        write_byte(8'h55, 1'b1, "t3_data_nack");
        send_stop();
        tick(20);
        check("t3_busy_seen", busy_seen, 0);

        // 4: write 0x01, repeated START, read 0x77
        s0 = n_start; r0 = n_rd;
        exp_q.push_back({1'b1, 8'h01});
        send_start();
        write_byte(8'hA0, 1'b0, "t4_addr_ack");
        write_byte(8'h01, 1'b0, "t4_d0_ack");
        send_start();
        write_byte(8'hA1, 1'b0, "t4_raddr_ack");
        read_byte(1'b1, d);
        check("t4_rd", d, 8'h77);
        send_stop();
        tick(20);
        check("t4_starts", n_start - s0, 2);
        check("t4_rd_pulses", n_rd - r0, 1);

        // 5: holding register full on the second write byte
        m_wr_ready = 1'b0;
        exp_q.push_back({1'b1, 8'h11});
`ifdef I2C_STARGET_STRETCH_EN
        exp_q.push_back({1'b0, 8'h22});
        fork
            begin
                int n;
                n = 0;
                while (scl_t !== 1'b0 && n < LIMIT) begin
                    tick(1);
                    n++;
                end
                tick(100);
                m_wr_ready = 1'b1;
            end
        join_none
`endif
        send_start();
        write_byte(8'hA0, 1'b0, "t5_addr_ack");
        write_byte(8'h11, 1'b0, "t5_d0_ack");
`ifdef I2C_STARGET_STRETCH_EN
        write_byte(8'h22, 1'b0, "t5_d1_ack_stretched");
        check("t5_stretch_seen", int'(last_stretch > 50), 1);
`else
        write_byte(8'h22, 1'b1, "t5_d1_nack");
`endif
        send_stop();
        m_wr_ready = 1'b1;
        tick(20);
        check("t5_wr_valid_drained", m_wr_valid, 0);

        // 6: reset during RD_BYTE while SDA is pulled low
        r0 = n_rd;
        send_start();
        write_byte(8'hA1, 1'b0, "t6_addr_ack");
        get_bit(b);
        get_bit(b);
        tick(10);
        check("t6_sda_low_pre", sda_t, 0);
        check("t6_rd_pulses", n_rd - r0, 1);
        rst_n = 1'b0;
        tick(1);
        check("t6_rst_sda_t", sda_t, 1);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_scl_t", scl_t, 1);
        scl_m = 1'b1;
        sda_m = 1'b1;
        tick(20);
        rst_n = 1'b1;
        tick(50);
        s0 = n_start;
        exp_q.push_back({1'b1, 8'h99});
        send_start();
        write_byte(8'hA0, 1'b0, "t6_post_addr_ack");
        write_byte(8'h99, 1'b0, "t6_post_d0_ack");
        send_stop();
        tick(20);
        check("t6_post_starts", n_start - s0, 1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
